hx8352_init_sequencer: RTL
==========================

Name: hx8352_init_sequencer

Overview:
Upstream command/data source for hx8352_controller.
- On start, pulses the panel hardware reset and waits for the panel to come out of reset.
- Replays a fixed init table of command words, data words and millisecond delays.
- Finishes by streaming a full-screen fill of one colour.
- Output is a valid/ready word stream: dc flag plus 16-bit word, which the controller turns into lcd_rs/lcd_wr strobes.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- TICKS_PER_MS, CLK_FREQ/1000, clocks per millisecond delay unit. Benches override with a small value.
- RST_LOW_MS, 1, lcd_rst_n low time in ms.
- RST_WAIT_MS, 120, wait after lcd_rst_n release before the first table fetch.
- ROM_DEPTH, 64, number of init-table entries.
- WIDTH, 240, panel width in pixels.
- HEIGHT, 400, panel height in pixels.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sequence when idle.
- fill_color  in  16  RGB565 fill colour, sampled when start is accepted.
- out_valid  out  1  word available on out_dc/out_data.
- out_dc  out  1  0 = command (LCD_CMD), 1 = data (LCD_DATA).
- out_data  out  16  word to the controller.
- out_ready  in  1  controller accepts the word this cycle.
- lcd_rst_n  out  1  panel hardware reset, active low.
- busy  out  1  sequence in progress.
- done  out  1  sticky: sequence completed.

Behaviour:
- Reset values: out_valid=0, out_dc=0, out_data=0, lcd_rst_n=1, busy=0, done=0, state=IDLE.
- Reset is synchronous and has priority at any point, including mid-sequence: next cycle is IDLE with all outputs at reset values.
- Table entry format is 18 bits: op[17:16], arg[15:0].
  - OP_CMD=0: emit arg with dc=0.
  - OP_DATA=1: emit arg with dc=1.
  - OP_DELAY=2: wait arg ms. arg=0 costs 1 cycle and no wait.
  - OP_END=3: end of table.
- States:
  - IDLE: on start, latch fill_color, clear done, set busy, go to RST_LOW.
  - RST_LOW: lcd_rst_n=0 for RST_LOW_MS*TICKS_PER_MS cycles, then RST_WAIT.
  - RST_WAIT: lcd_rst_n=1 for RST_WAIT_MS*TICKS_PER_MS cycles, then FETCH with idx=0.
  - FETCH: one cycle; reads rom[idx] (registered ROM, 1-cycle latency), then DECODE.
  - DECODE:
    - CMD/DATA: drive out_*, go to ISSUE.
    - DELAY: load counter, go to WAIT.
    - END: go to FILL_CMD.
  - ISSUE: out_valid=1 with out_dc/out_data held stable until out_valid&&out_ready. On transfer, out_valid=0 next cycle, idx+1, FETCH.
  - WAIT: count arg*TICKS_PER_MS cycles, then idx+1, FETCH.
  - FILL_CMD: emit CMD 0x0022 (GRAM write) with the same handshake, then FILL.
  - FILL: out_valid=1, dc=1, data=latched colour, for WIDTH*HEIGHT transfers. The pixel counter is 17 bits and increments only on handshake. After the last transfer go to FIN.
  - FIN: one cycle, busy=0, done=1, then IDLE.
- Throughput: 1 table word per 3 cycles minimum (FETCH, DECODE, ISSUE). FILL sustains 1 word/cycle while out_ready=1.
- Boundaries:
  - idx reaching ROM_DEPTH without OP_END is treated as OP_END.
  - start while busy is ignored.
  - start in the same cycle as rst is ignored.
  - out_ready while out_valid=0 is ignored.
  - out_ready held low stalls indefinitely with no word loss or duplication.
  - The delay counter is 32 bits. Multiplication by TICKS_PER_MS is done by a nested ms-tick counter, not a multiplier.
- Table contents, first entries fixed:
  - 0: CMD 0x0083
  - 1: DATA 0x0002
  - 2: DELAY 5
  - 3: CMD 0x0085
  - 4: DATA 0x0003
  - then the HX8352 power/gamma/window setup to the full WIDTH×HEIGHT, ending OP_END.

Decomposition:
- Package hx8352_pkg holds:
  - OP_CMD, OP_DATA, OP_DELAY, OP_END;
  - LCD_CMD=0, LCD_DATA=1;
  - CMD_GRAM_WRITE=16'h0022;
  - the state encoding.
- One sub-module, hx8352_init_rom: a case-based synchronous ROM with inputs clk and addr, output entry[17:0]. The sequencer holds the FSM, counters and handshake.

Test Plan:
- TICKS_PER_MS=4, start with fill_color=16'hF800, out_ready=1 -> lcd_rst_n low exactly 4 cycles then high 480 cycles. First words are (0,0x0083), (1,0x0002). No word for ≥20 cycles. Then (0,0x0085), (1,0x0003).
- Stall: out_ready low 10 cycles while word (0,0x0083) is pending -> out_valid stays 1, data stable, exactly one transfer once ready rises.
- Fill with WIDTH=4, HEIGHT=3 -> after table, one (0,0x0022) then exactly 12 transfers of (1,0xF800); done=1, busy=0 one cycle after FIN.
- Random out_ready (50%) across the full run -> transferred word sequence identical to the ready=1 run.
- rst asserted mid-FILL -> next cycle out_valid=0, busy=0, done=0, lcd_rst_n=1. A new start repeats the full sequence from RST_LOW.
- start pulsed while busy -> ignored, sequence and word count unchanged. start after done -> done clears, new sequence runs.

Source files
------------

// File: rtl/hx8352_pkg.sv
// hx8352_pkg: shared definitions for the HX8352 init sequencer.
//   - op_e       : init-table opcodes stored in entry[17:16]
//   - LCD_CMD / LCD_DATA : dc flag values on the word stream
//   - CMD_GRAM_WRITE     : command that opens the GRAM write window
//   - state_e    : sequencer FSM encoding
//   - rom_entry  : packs an opcode and argument into an 18-bit table entry
package hx8352_pkg;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_e;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  localparam logic [15:0] CMD_GRAM_WRITE = 16'h0022;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RST_LOW  = 4'd1,
    ST_RST_WAIT = 4'd2,
    ST_FETCH    = 4'd3,
    ST_DECODE   = 4'd4,
    ST_ISSUE    = 4'd5,
    ST_WAIT     = 4'd6,
    ST_FILL_CMD = 4'd7,
    ST_FILL     = 4'd8,
    ST_FIN      = 4'd9
  } state_e;

  function automatic logic [17:0] rom_entry(input op_e op, input logic [15:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/hx8352_init_rom.sv
// hx8352_init_rom: registered (1-cycle latency) init table for the HX8352.
//   clk   : system clock
//   addr  : table index
//   entry : {op[17:16], arg[15:0]} of rom[addr], valid one cycle after addr
// The window setup at the end covers the full WIDTH x HEIGHT panel.
// Addresses past the last entry read back as OP_END.
module hx8352_init_rom
  import hx8352_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 400
) (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [17:0] entry
);

  localparam logic [15:0] COL_END = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_END = 16'(HEIGHT - 1);

  // Synchronous table read
  always_ff @(posedge clk) begin
    case (addr)
      8'd0:    entry <= rom_entry(OP_CMD,   16'h0083);  // test mode on
      8'd1:    entry <= rom_entry(OP_DATA,  16'h0002);
      8'd2:    entry <= rom_entry(OP_DELAY, 16'd5);
      8'd3:    entry <= rom_entry(OP_CMD,   16'h0085);  // VDC select
      8'd4:    entry <= rom_entry(OP_DATA,  16'h0003);
      8'd5:    entry <= rom_entry(OP_CMD,   16'h008B);
      8'd6:    entry <= rom_entry(OP_DATA,  16'h0001);
      8'd7:    entry <= rom_entry(OP_CMD,   16'h008C);
      8'd8:    entry <= rom_entry(OP_DATA,  16'h0093);
      8'd9:    entry <= rom_entry(OP_CMD,   16'h0091);
      8'd10:   entry <= rom_entry(OP_DATA,  16'h0001);
      8'd11:   entry <= rom_entry(OP_CMD,   16'h0083);  // test mode off
      8'd12:   entry <= rom_entry(OP_DATA,  16'h0000);
      8'd13:   entry <= rom_entry(OP_CMD,   16'h003E);  // gamma
      8'd14:   entry <= rom_entry(OP_DATA,  16'h00B0);
      8'd15:   entry <= rom_entry(OP_CMD,   16'h0017);  // 16-bit colour
      8'd16:   entry <= rom_entry(OP_DATA,  16'h0005);
      8'd17:   entry <= rom_entry(OP_CMD,   16'h002B);  // oscillator on
      8'd18:   entry <= rom_entry(OP_DATA,  16'h0001);
      8'd19:   entry <= rom_entry(OP_CMD,   16'h001B);  // power control
      8'd20:   entry <= rom_entry(OP_DATA,  16'h0014);
      8'd21:   entry <= rom_entry(OP_DELAY, 16'd10);
      8'd22:   entry <= rom_entry(OP_CMD,   16'h0028);  // display on, stage 1
      8'd23:   entry <= rom_entry(OP_DATA,  16'h0038);
      8'd24:   entry <= rom_entry(OP_DELAY, 16'd4);
      8'd25:   entry <= rom_entry(OP_CMD,   16'h0028);  // display on, stage 2
      8'd26:   entry <= rom_entry(OP_DATA,  16'h003C);
      8'd27:   entry <= rom_entry(OP_CMD,   16'h0002);  // column start
      8'd28:   entry <= rom_entry(OP_DATA,  16'h0000);
      8'd29:   entry <= rom_entry(OP_CMD,   16'h0003);
      8'd30:   entry <= rom_entry(OP_DATA,  16'h0000);
      8'd31:   entry <= rom_entry(OP_CMD,   16'h0004);  // column end
      8'd32:   entry <= rom_entry(OP_DATA,  {8'h00, COL_END[15:8]});
      8'd33:   entry <= rom_entry(OP_CMD,   16'h0005);
      8'd34:   entry <= rom_entry(OP_DATA,  {8'h00, COL_END[7:0]});
      8'd35:   entry <= rom_entry(OP_CMD,   16'h0006);  // row start
      8'd36:   entry <= rom_entry(OP_DATA,  16'h0000);
      8'd37:   entry <= rom_entry(OP_CMD,   16'h0007);
      8'd38:   entry <= rom_entry(OP_DATA,  16'h0000);
      8'd39:   entry <= rom_entry(OP_CMD,   16'h0008);  // row end
      8'd40:   entry <= rom_entry(OP_DATA,  {8'h00, ROW_END[15:8]});
      8'd41:   entry <= rom_entry(OP_CMD,   16'h0009);
      8'd42:   entry <= rom_entry(OP_DATA,  {8'h00, ROW_END[7:0]});
      8'd43:   entry <= rom_entry(OP_END,   16'h0000);
      default: entry <= rom_entry(OP_END,   16'h0000);
    endcase
  end

endmodule

// File: rtl/hx8352_init_sequencer.sv
// hx8352_init_sequencer: drives the HX8352 power-up sequence as a word stream.
//   clk, rst          : clock, synchronous active-high reset
//   start, fill_color : begin a sequence when idle; colour latched on accept
//   out_valid/out_dc/out_data/out_ready : valid/ready word stream to controller
//   lcd_rst_n         : panel hardware reset (active low)
//   busy, done        : sequence running / sticky completion flag
// Flow: panel reset pulse, settle wait, init-table replay, GRAM write
// command, then WIDTH*HEIGHT pixels of the latched colour.
module hx8352_init_sequencer
  import hx8352_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int TICKS_PER_MS = CLK_FREQ / 1000,
  parameter int RST_LOW_MS   = 1,
  parameter int RST_WAIT_MS  = 120,
  parameter int ROM_DEPTH    = 64,
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] fill_color,
  output logic        out_valid,
  output logic        out_dc,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        lcd_rst_n,
  output logic        busy,
  output logic        done
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int IW = $clog2(ROM_DEPTH + 1);
  localparam logic [TW-1:0] TICK_LAST     = TW'(TICKS_PER_MS - 1);
  localparam logic [IW-1:0] IDX_END       = IW'(ROM_DEPTH);
  localparam logic [16:0]   PIX_LAST      = 17'(WIDTH * HEIGHT - 1);
  // Reset timings are assumed to be at least 1 ms
  localparam logic [31:0]   RST_LOW_TIME  = 32'(RST_LOW_MS);
  localparam logic [31:0]   RST_WAIT_TIME = 32'(RST_WAIT_MS);

  state_e         state_r, state_s;
  logic [IW-1:0]  idx_r, idx_s;
  logic [TW-1:0]  tick_r, tick_s, tick_step_s;
  logic [31:0]    ms_left_r, ms_left_s, ms_step_s;
  logic [16:0]    pix_r, pix_s;
  logic [15:0]    color_r, color_s;
  logic           out_valid_r, out_valid_s;
  logic           out_dc_r, out_dc_s;
  logic [15:0]    out_data_r, out_data_s;
  logic           lcd_rst_n_r, lcd_rst_n_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;

  logic [17:0]    rom_entry_s;
  op_e            op_s;
  logic [15:0]    arg_s;
  logic           xfer_s;
  logic           ms_tick_s;
  logic           timer_done_s;
  logic           table_end_s;

  hx8352_init_rom #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_rom (
    .clk   (clk),
    .addr  (8'(idx_r)),
    .entry (rom_entry_s)
  );

  assign op_s   = op_e'(rom_entry_s[17:16]);
  assign arg_s  = rom_entry_s[15:0];
  assign xfer_s = out_valid_r && out_ready;
  // Running off the end of the table behaves like an explicit OP_END
  assign table_end_s = (idx_r == IDX_END) || (op_s == OP_END);

  // Nested delay timer: tick_r counts clocks within a ms, ms_left_r counts ms
  assign ms_tick_s    = (tick_r == TICK_LAST);
  assign timer_done_s = ms_tick_s && (ms_left_r == 32'd1);
  assign tick_step_s  = ms_tick_s ? {TW{1'b0}} : tick_r + TW'(1'b1);
  assign ms_step_s    = ms_tick_s ? ms_left_r - 32'd1 : ms_left_r;

  assign out_valid = out_valid_r;
  assign out_dc    = out_dc_r;
  assign out_data  = out_data_r;
  assign lcd_rst_n = lcd_rst_n_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next-state and next-output logic; outputs are registered one cycle later
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    tick_s      = tick_r;
    ms_left_s   = ms_left_r;
    pix_s       = pix_r;
    color_s     = color_r;
    out_valid_s = out_valid_r;
    out_dc_s    = out_dc_r;
    out_data_s  = out_data_r;
    lcd_rst_n_s = lcd_rst_n_r;
    busy_s      = busy_r;
    done_s      = done_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          color_s     = fill_color;
          done_s      = 1'b0;
          busy_s      = 1'b1;
          lcd_rst_n_s = 1'b0;
          tick_s      = {TW{1'b0}};
          ms_left_s   = RST_LOW_TIME;
          state_s     = ST_RST_LOW;
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_RST_LOW: begin
        if (timer_done_s) begin
          lcd_rst_n_s = 1'b1;
          tick_s      = {TW{1'b0}};
          ms_left_s   = RST_WAIT_TIME;
          state_s     = ST_RST_WAIT;
        end else begin
          tick_s    = tick_step_s;
          ms_left_s = ms_step_s;
        end
      end
      ST_RST_WAIT: begin
        if (timer_done_s) begin
          idx_s   = {IW{1'b0}};
          state_s = ST_FETCH;
        end else begin
          tick_s    = tick_step_s;
          ms_left_s = ms_step_s;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (table_end_s) begin
          out_valid_s = 1'b1;
          out_dc_s    = LCD_CMD;
          out_data_s  = CMD_GRAM_WRITE;
          pix_s       = 17'd0;
          state_s     = ST_FILL_CMD;
        end else if (op_s == OP_DELAY) begin
          if (arg_s == 16'd0) begin
            idx_s   = idx_r + IW'(1'b1);
            state_s = ST_FETCH;
          end else begin
            tick_s    = {TW{1'b0}};
            ms_left_s = {16'd0, arg_s};
            state_s   = ST_WAIT;
          end
        end else begin
          out_valid_s = 1'b1;
          out_dc_s    = (op_s == OP_DATA) ? LCD_DATA : LCD_CMD;
          out_data_s  = arg_s;
          state_s     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (xfer_s) begin
          out_valid_s = 1'b0;
          idx_s       = idx_r + IW'(1'b1);
          state_s     = ST_FETCH;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (timer_done_s) begin
          idx_s   = idx_r + IW'(1'b1);
          state_s = ST_FETCH;
        end else begin
          tick_s    = tick_step_s;
          ms_left_s = ms_step_s;
        end
      end
      ST_FILL_CMD: begin
        // valid stays high so pixels follow the command back-to-back
        if (xfer_s) begin
          out_dc_s   = LCD_DATA;
          out_data_s = color_r;
          state_s    = ST_FILL;
        end else begin
          state_s = ST_FILL_CMD;
        end
      end
      ST_FILL: begin
        if (xfer_s) begin
          if (pix_r == PIX_LAST) begin
            out_valid_s = 1'b0;
            state_s     = ST_FIN;
          end else begin
            pix_s = pix_r + 17'd1;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_FIN: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        lcd_rst_n_s = 1'b1;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers; rst overrides any pending update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IW{1'b0}};
      tick_r      <= {TW{1'b0}};
      ms_left_r   <= 32'd0;
      pix_r       <= 17'd0;
      color_r     <= 16'h0000;
      out_valid_r <= 1'b0;
      out_dc_r    <= 1'b0;
      out_data_r  <= 16'h0000;
      lcd_rst_n_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      tick_r      <= tick_s;
      ms_left_r   <= ms_left_s;
      pix_r       <= pix_s;
      color_r     <= color_s;
      out_valid_r <= out_valid_s;
      out_dc_r    <= out_dc_s;
      out_data_r  <= out_data_s;
      lcd_rst_n_r <= lcd_rst_n_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

endmodule
